f11_qdma_arb: RTL

- Q-bus DMA arbiter for the F-11 processor board.
- Shares the Q-bus between the CPU bus-cycle sequencer and up to NREQ DMA requesters.
- Blocks new CPU cycles, waits for the current CPU cycle to finish, issues a one-hot grant, then tracks SACK-based bus tenure.
- Sits beside the CPU wrapper's bus-cycle logic. cpu_hold feeds the CPU wait/clock-stretch term.

---
 rtl/f11_qdma_arb_if.sv | 43 ++++
 rtl/f11_qdma_arb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/f11_qdma_arb_if.sv
// ---------------------------------------------------------------------------
// f11_qdma_arb_if
// Purpose : bundles the Q-bus DMA arbitration signals shared between the
//           arbiter and its surroundings (DMA devices, CPU bus-cycle logic).
// Signals :
//   dma_req  [NREQ] DMA requests, level, active high
//   dma_sack [NREQ] selection acknowledge per requester
//   dma_gnt  [NREQ] grant, one-hot or zero
//   cpu_busy        CPU owns the bus (SYNC asserted or transfer pending)
//   bus_sync        Q-bus SYNC from any master
//   cpu_hold        inhibits the CPU from starting a new bus cycle
//   arb_busy        arbiter state is not IDLE
//   sack_to         one-cycle pulse on SACK timeout
//   ten_err         sticky tenure-watchdog flag
// Modports:
//   master : the arbiter side (drives grant/hold/status)
//   slave  : the environment side (drives requests, acks, CPU/bus status)
// ---------------------------------------------------------------------------
interface f11_qdma_arb_if #(
  parameter int NREQ = 4
) ();

  logic [NREQ-1:0] dma_req;
  logic [NREQ-1:0] dma_sack;
  logic [NREQ-1:0] dma_gnt;
  logic            cpu_busy;
  logic            bus_sync;
  logic            cpu_hold;
  logic            arb_busy;
  logic            sack_to;
  logic            ten_err;

  modport master (
    input  dma_req, dma_sack, cpu_busy, bus_sync,
    output dma_gnt, cpu_hold, arb_busy, sack_to, ten_err
  );

  modport slave (
    output dma_req, dma_sack, cpu_busy, bus_sync,
    input  dma_gnt, cpu_hold, arb_busy, sack_to, ten_err
  );

endinterface

// File: rtl/f11_qdma_arb.sv
// ---------------------------------------------------------------------------
// f11_qdma_arb
// Purpose : Q-bus DMA arbiter for the F-11 processor board. Holds off new CPU
//           bus cycles, waits for the current CPU cycle to end, grants one
//           DMA requester and tracks its SACK-based bus tenure. A one-cycle
//           GAP after each tenure leaves the CPU an arbitration slot.
// Ports   :
//   pin_clk   processor clock, all state changes on the rising edge
//   pin_init  synchronous active-high reset
//   bus       f11_qdma_arb_if.master (dma_req/dma_sack/dma_gnt, cpu_busy,
//             bus_sync, cpu_hold, arb_busy, sack_to, ten_err)
// Parameters:
//   NREQ     number of DMA requesters (1..8)
//   SACK_TO  cycles allowed between grant and SACK (>=2)
//   TEN_TO   maximum MASTER tenure in cycles, 0 disables the watchdog
// Build option:
//   F11_DMA_RR_EN  defined   -> round-robin priority starting after the
//                               last winner
//                  undefined -> fixed priority, index 0 highest
// ---------------------------------------------------------------------------
module f11_qdma_arb #(
  parameter int NREQ    = 4,
  parameter int SACK_TO = 64,
  parameter int TEN_TO  = 0
) (
  input  logic            pin_clk,
  input  logic            pin_init,
  f11_qdma_arb_if.master  bus
);

  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMAX0 = (SACK_TO > TEN_TO) ? SACK_TO : TEN_TO;
  localparam int TMAX  = (TMAX0 > 2) ? TMAX0 : 2;
  localparam int TW    = $clog2(TMAX) + 1;

  localparam logic [TW-1:0] SACK_LAST = TW'(SACK_TO - 1);
  localparam logic [TW-1:0] TEN_LAST  = TW'((TEN_TO > 0) ? TEN_TO - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_GRANT,
    S_MASTER,
    S_GAP
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [IW-1:0]   r_winner;
  logic [IW-1:0]   w_pick;
  logic [IW-1:0]   w_start;
  logic            w_anyReq;
  logic [TW-1:0]   r_timer;
  logic            r_sackTo;
  logic            r_tenErr;
  logic            w_reqW;
  logic            w_sackW;
  logic            w_toExit;
  logic [NREQ-1:0] w_gnt;
  logic            w_hold;

  assign w_reqW  = bus.dma_req[r_winner];
  assign w_sackW = bus.dma_sack[r_winner];

  // A timeout only counts when neither SACK nor a withdrawal already
  // decided the exit from GRANT.
  assign w_toExit = (r_state == S_GRANT) && !w_sackW && w_reqW &&
                    (r_timer >= SACK_LAST);

`ifdef F11_DMA_RR_EN
  logic [IW-1:0] r_ptr;
  logic          w_ptrAdvance;
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  // Withdrawn requests do not move the pointer; completed tenures and
  // timeouts do.
  assign w_ptrAdvance = ((r_state == S_MASTER) && (w_nextState == S_GAP)) ||
                        w_toExit;
  assign w_start      = r_ptr;

  always_ff @(posedge pin_clk) begin
    if (pin_init) begin
      r_ptr <= '0;
    end else if (w_ptrAdvance) begin
      r_ptr <= (r_winner == LAST_IDX) ? '0 : r_winner + IW'(1);
    end
  end
`else
  assign w_start = '0;
`endif

  // Priority search beginning at w_start and wrapping past NREQ-1 to 0.
  always_comb begin
    int idx;
    idx      = 0;
    w_pick   = '0;
    w_anyReq = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(w_start) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_anyReq && bus.dma_req[idx]) begin
        w_anyReq = 1'b1;
        w_pick   = IW'(idx);
      end
    end
  end

  always_ff @(posedge pin_clk) begin
    if (pin_init) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (w_anyReq) w_nextState = S_HOLD;
      S_HOLD: begin
        if (!w_reqW)            w_nextState = S_GAP;
        else if (!bus.cpu_busy) w_nextState = S_GRANT;
      end
      S_GRANT: begin
        if (w_sackW)            w_nextState = S_MASTER;
        else if (!w_reqW)       w_nextState = S_GAP;
        else if (w_toExit)      w_nextState = S_GAP;
      end
      S_MASTER: if (!w_sackW && !bus.bus_sync) w_nextState = S_GAP;
      S_GAP:    w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    w_gnt  = '0;
    w_hold = 1'b0;
    case (r_state)
      S_HOLD:   w_hold = 1'b1;
      S_GRANT: begin
        w_hold          = 1'b1;
        w_gnt[r_winner] = 1'b1;
      end
      S_MASTER: w_hold = 1'b1;
      default: begin
        w_gnt  = '0;
        w_hold = 1'b0;
      end
    endcase
  end

  // Winner is frozen from IDLE onwards so late requests cannot steal the grant.
  always_ff @(posedge pin_clk) begin
    if (pin_init) begin
      r_winner <= '0;
    end else if ((r_state == S_IDLE) && w_anyReq) begin
      r_winner <= w_pick;
    end
  end

  // One timer serves both the SACK timeout (GRANT) and the tenure watchdog
  // (MASTER); it restarts on every state change and saturates.
  always_ff @(posedge pin_clk) begin
    if (pin_init) begin
      r_timer <= '0;
    end else if (w_nextState != r_state) begin
      r_timer <= '0;
    end else if (((r_state == S_GRANT) || (r_state == S_MASTER)) &&
                 (r_timer != '1)) begin
      r_timer <= r_timer + TW'(1);
    end
  end

  always_ff @(posedge pin_clk) begin
    if (pin_init) begin
      r_sackTo <= 1'b0;
      r_tenErr <= 1'b0;
    end else begin
      r_sackTo <= w_toExit;
      if ((TEN_TO > 0) && (r_state == S_MASTER) && (r_timer >= TEN_LAST)) begin
        r_tenErr <= 1'b1;
      end
    end
  end

  assign bus.dma_gnt  = w_gnt;
  assign bus.cpu_hold = w_hold;
  assign bus.arb_busy = (r_state != S_IDLE);
  assign bus.sack_to  = r_sackTo;
  assign bus.ten_err  = r_tenErr;

endmodule
